// File: rtl/meta_array_pkg.sv
// Shared types and helpers for the L1 metadata array.
package meta_array_pkg;

  typedef enum logic [0:0] {IDLE, FLUSH} flush_state_t;

  // Bit offset of way w inside the packed multi-way read bus.
  function automatic int unsigned way_offset(input int unsigned w, input int unsigned width);
    return w * width;
  endfunction

endpackage

// File: rtl/meta_array_if.sv
// Controller-side bus of the metadata array: read, write/invalidate and flush signals.
interface meta_array_if #(
  parameter int unsigned S_INDEX = 3,
  parameter int unsigned WIDTH   = 24,
  parameter int unsigned WAYS    = 2
);
  logic [S_INDEX-1:0]    rindex;
  logic [WAYS*WIDTH-1:0] dataout;
  logic [WAYS-1:0]       valid_out;
  logic [S_INDEX-1:0]    windex;
  logic [WAYS-1:0]       write_en;
  logic [WIDTH-1:0]      datain;
  logic [WAYS-1:0]       inval_en;
  logic                  flush_req;
  logic                  flush_busy;

  modport master (
    output rindex, windex, write_en, datain, inval_en, flush_req,
    input  dataout, valid_out, flush_busy
  );

  modport slave (
    input  rindex, windex, write_en, datain, inval_en, flush_req,
    output dataout, valid_out, flush_busy
  );
endinterface

// File: rtl/meta_array_way.sv
// One way of tag/state storage with valid bits; async read, sync write/invalidate/clear.
// META_ARRAY_BYPASS_EN enables the same-cycle write-to-read forward.
module meta_array_way #(
  parameter int unsigned S_INDEX = 3,
  parameter int unsigned WIDTH   = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [S_INDEX-1:0] rindex,
  input  logic [S_INDEX-1:0] windex,
  input  logic               write_en,
  input  logic               inval_en,
  input  logic [WIDTH-1:0]   datain,
  input  logic               clear_en,
  input  logic [S_INDEX-1:0] clear_idx,
  output logic [WIDTH-1:0]   rdata,
  output logic               rvalid
);
  localparam int unsigned NUM_SETS = 2 ** S_INDEX;

  logic [WIDTH-1:0] data_q [NUM_SETS];
  logic             vld_q  [NUM_SETS];

  // Strobes arrive pre-gated: write/invalidate and clear are never active together.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SETS; i++) begin
        data_q[i] <= '0;
        vld_q[i]  <= 1'b0;
      end
    end else begin
      if (write_en) begin
        data_q[windex] <= datain;
        vld_q[windex]  <= 1'b1;
      end else if (inval_en) begin
        vld_q[windex] <= 1'b0;
      end
      if (clear_en) begin
        vld_q[clear_idx] <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata  = data_q[rindex];
    rvalid = vld_q[rindex];
`ifdef META_ARRAY_BYPASS_EN
    if (write_en && (rindex == windex)) begin
      rdata  = datain;
      rvalid = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/meta_array.sv
// Multi-way L1 metadata array: flush FSM, strobe gating and per-way storage instances.
// Optional same-cycle bypass selected by META_ARRAY_BYPASS_EN (see meta_array_way).
module meta_array
  import meta_array_pkg::*;
#(
  parameter int unsigned S_INDEX = 3,
  parameter int unsigned WIDTH   = 24,
  parameter int unsigned WAYS    = 2
) (
  input logic         clk,
  input logic         rst,
  meta_array_if.slave bus
);
  localparam int unsigned NUM_SETS = 2 ** S_INDEX;
  localparam logic [S_INDEX-1:0] LastSet = S_INDEX'(NUM_SETS - 1);

  flush_state_t       state_q, state_d;
  logic [S_INDEX-1:0] cnt_q, cnt_d;
  logic               in_flush;
  logic [WAYS-1:0]    we_gated, ie_gated, way_vld;
  logic [WIDTH-1:0]   way_data [WAYS];

  assign in_flush = (state_q == FLUSH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.flush_req) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        cnt_d = cnt_q + S_INDEX'(1);
        if (cnt_q == LastSet) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gating the strobes also disables the per-way bypass while flushing.
  assign we_gated = in_flush ? '0 : bus.write_en;
  assign ie_gated = in_flush ? '0 : bus.inval_en;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    meta_array_way #(
      .S_INDEX(S_INDEX),
      .WIDTH  (WIDTH)
    ) u_way (
      .clk      (clk),
      .rst      (rst),
      .rindex   (bus.rindex),
      .windex   (bus.windex),
      .write_en (we_gated[w]),
      .inval_en (ie_gated[w]),
      .datain   (bus.datain),
      .clear_en (in_flush),
      .clear_idx(cnt_q),
      .rdata    (way_data[w]),
      .rvalid   (way_vld[w])
    );
    assign bus.dataout[way_offset(w, WIDTH) +: WIDTH] = way_data[w];
  end

  assign bus.valid_out  = in_flush ? '0 : way_vld;
  assign bus.flush_busy = in_flush;

endmodule

// File: tb/tb_meta_array.sv
// Self-checking bench for meta_array against a behavioural set/way model.
module tb_meta_array;
  localparam int S_INDEX = 3;
  localparam int WIDTH   = 8;
  localparam int WAYS    = 2;
  localparam int NSETS   = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  meta_array_if #(.S_INDEX(S_INDEX), .WIDTH(WIDTH), .WAYS(WAYS)) bus ();

  meta_array #(.S_INDEX(S_INDEX), .WIDTH(WIDTH), .WAYS(WAYS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: contents per way/set, plus flush progress.
  logic [7:0] m_data [WAYS][NSETS];
  bit         m_vld  [WAYS][NSETS];
  bit         m_busy;
  int         m_next_clear;

`ifdef META_ARRAY_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  function automatic logic [15:0] exp_dout();
    logic [15:0] r;
    for (int w = 0; w < WAYS; w++) begin
      if (Bypass && !m_busy && bus.write_en[w] && bus.rindex == bus.windex)
        r[w*8 +: 8] = bus.datain;
      else
        r[w*8 +: 8] = m_data[w][bus.rindex];
    end
    return r;
  endfunction

  function automatic logic [1:0] exp_vout();
    logic [1:0] r;
    for (int w = 0; w < WAYS; w++) begin
      if (m_busy) r[w] = 1'b0;
      else if (Bypass && bus.write_en[w] && bus.rindex == bus.windex) r[w] = 1'b1;
      else r[w] = m_vld[w][bus.rindex];
    end
    return r;
  endfunction

  // Advance one clock edge, applying the same edge to the model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < NSETS; s++) begin
          m_data[w][s] = '0;
          m_vld[w][s]  = 1'b0;
        end
      m_busy = 1'b0;
    end else if (m_busy) begin
      for (int w = 0; w < WAYS; w++) m_vld[w][m_next_clear] = 1'b0;
      m_next_clear++;
      if (m_next_clear == NSETS) m_busy = 1'b0;
    end else begin
      for (int w = 0; w < WAYS; w++) begin
        if (bus.write_en[w]) begin
          m_data[w][bus.windex] = bus.datain;
          m_vld[w][bus.windex]  = 1'b1;
        end else if (bus.inval_en[w]) begin
          m_vld[w][bus.windex] = 1'b0;
        end
      end
      if (bus.flush_req) begin
        m_busy       = 1'b1;
        m_next_clear = 0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.write_en  = '0;
    bus.inval_en  = '0;
    bus.flush_req = 1'b0;
    bus.windex    = '0;
    bus.datain    = '0;
  endtask

  task automatic write_set(input logic [1:0] ways, input int set, input logic [7:0] d);
    bus.write_en = ways;
    bus.windex   = 3'(set);
    bus.datain   = d;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.rindex = '0;
    tick();
    tick();
    rst = 1'b0;
    for (int s = 0; s < NSETS; s++) begin
      bus.rindex = 3'(s);
      #1;
      n_tests++;
      if (bus.dataout !== 16'h0000 || bus.valid_out !== 2'b00 || bus.flush_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset set %0d: dataout=%h valid=%b busy=%b, want 0000/00/0",
                 s, bus.dataout, bus.valid_out, bus.flush_busy);
      end
    end
  endtask

  task automatic test_bypass_write();
    bus.write_en = 2'b01;
    bus.windex   = 3'd5;
    bus.datain   = 8'hA5;
    bus.rindex   = 3'd5;
    #1;
    n_tests++;
    if (bus.dataout !== exp_dout() || bus.valid_out !== exp_vout()) begin
      n_fail++;
      $display("FAIL bypass_same_cycle: dataout=%h valid=%b, want %h/%b",
               bus.dataout, bus.valid_out, exp_dout(), exp_vout());
    end
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if (bus.dataout[7:0] !== 8'hA5 || bus.valid_out !== 2'b01) begin
      n_fail++;
      $display("FAIL bypass_next_cycle: way0=%h valid=%b, want a5/01",
               bus.dataout[7:0], bus.valid_out);
    end
  endtask

  task automatic test_write_inval_priority();
    write_set(2'b11, 3, 8'h11);
    bus.write_en = 2'b10;
    bus.inval_en = 2'b11;
    bus.windex   = 3'd3;
    bus.datain   = 8'h3C;
    tick();
    idle_inputs();
    bus.rindex = 3'd3;
    #1;
    n_tests++;
    if (bus.valid_out !== 2'b10 || bus.dataout !== 16'h3C11) begin
      n_fail++;
      $display("FAIL write_over_inval: dataout=%h valid=%b, want 3c11/10",
               bus.dataout, bus.valid_out);
    end
  endtask

  task automatic test_flush();
    int busy_cycles = 0;
    for (int s = 0; s < NSETS; s++) write_set(2'b11, s, 8'(8'h40 + s));
    bus.flush_req = 1'b1;
    bus.write_en  = 2'b01;
    bus.windex    = 3'd2;
    bus.datain    = 8'h77;
    tick();
    idle_inputs();
    for (int c = 0; c < NSETS + 3; c++) begin
      bus.rindex    = 3'($urandom_range(0, NSETS - 1));
      // Strobes and a second request while flushing must have no effect.
      bus.write_en  = 2'b11;
      bus.inval_en  = 2'($urandom);
      bus.windex    = 3'd1;
      bus.datain    = 8'hEE;
      bus.flush_req = (c == 2);
      #1;
      if (bus.flush_busy === 1'b1) busy_cycles++;
      n_tests++;
      if (bus.flush_busy !== m_busy || bus.valid_out !== exp_vout()
          || bus.dataout !== exp_dout()) begin
        n_fail++;
        $display("FAIL flush_cycle %0d: busy=%b valid=%b dout=%h, want %b/%b/%h", c,
                 bus.flush_busy, bus.valid_out, bus.dataout, m_busy, exp_vout(), exp_dout());
      end
      if (!m_busy) idle_inputs();
      tick();
    end
    idle_inputs();
    n_tests++;
    if (busy_cycles != NSETS) begin
      n_fail++;
      $display("FAIL flush_length: busy for %0d cycles, want %0d", busy_cycles, NSETS);
    end
    for (int s = 0; s < NSETS; s++) begin
      bus.rindex = 3'(s);
      #1;
      n_tests++;
      if (bus.valid_out !== 2'b00 || bus.dataout !== exp_dout()) begin
        n_fail++;
        $display("FAIL post_flush set %0d: valid=%b dout=%h, want 00/%h",
                 s, bus.valid_out, bus.dataout, exp_dout());
      end
    end
    bus.rindex = 3'd2;
    #1;
    n_tests++;
    if (bus.dataout[7:0] !== 8'h77) begin
      n_fail++;
      $display("FAIL flush_concurrent_write: way0 set2=%h, want 77", bus.dataout[7:0]);
    end
  endtask

  task automatic test_flush_reset();
    for (int s = 0; s < NSETS; s++) write_set(2'b11, s, 8'(8'h90 + s));
    bus.flush_req = 1'b1;
    tick();
    idle_inputs();
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_tests++;
    if (bus.flush_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort_busy: busy=%b, want 0", bus.flush_busy);
    end
    for (int s = 0; s < NSETS; s++) begin
      bus.rindex = 3'(s);
      #1;
      n_tests++;
      if (bus.dataout !== 16'h0000 || bus.valid_out !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_abort set %0d: dout=%h valid=%b, want 0000/00",
                 s, bus.dataout, bus.valid_out);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst           = ($urandom_range(0, 99) == 0);
      bus.rindex    = 3'($urandom);
      bus.windex    = ($urandom_range(0, 2) == 0) ? bus.rindex : 3'($urandom);
      bus.write_en  = 2'($urandom);
      bus.inval_en  = 2'($urandom);
      bus.datain    = 8'($urandom);
      bus.flush_req = ($urandom_range(0, 29) == 0);
      #1;
      n_tests++;
      if (bus.dataout !== exp_dout() || bus.valid_out !== exp_vout()
          || bus.flush_busy !== m_busy) begin
        n_fail++;
        $display("FAIL random %0d: dout=%h valid=%b busy=%b, want %h/%b/%b", c,
                 bus.dataout, bus.valid_out, bus.flush_busy, exp_dout(), exp_vout(), m_busy);
      end
      tick();
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    m_busy       = 1'b0;
    m_next_clear = 0;
    test_reset();
    test_bypass_write();
    test_write_inval_priority();
    test_flush();
    test_flush_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
